// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writes a program image into a writable instruction memory before the CPU is
// released. Bytes come in over a valid/ready stream. Each word is 16 bits, and
// one word is written per instruction at word-aligned byte addresses
// 0, 4, 8, ... The CPU is held in reset until a load completes successfully.
//
// Stream format:
//   N[15:8], N[7:0], then N instructions, each sent high byte first
//   (2-byte big-endian instruction count, big-endian instructions).
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   synchronous active-low reset
//   start     in   one-cycle pulse; begins a load from IDLE, DONE or ERROR
//   in_data   in   [7:0] stream byte
//   in_valid  in   in_data is valid
//   in_ready  out  loader accepts a byte this cycle (depends on state only)
//   wr_en     out  one-cycle memory write strobe
//   wr_addr   out  [ADDR_W-1:0] byte address of the write, bits [1:0] = 0
//   wr_data   out  [DATA_W-1:0] instruction word
//   busy      out  load in progress
//   done      out  last load completed successfully (sticky)
//   error     out  last load was rejected (sticky)
//   cpu_hold  out  high whenever done is low
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | after reset; waiting for start
// LEN_HI   | waiting for count byte N[15:8]
// LEN_LO   | waiting for count byte N[7:0]; N is checked on accept
// INSTR_HI | waiting for the high byte of instruction <index>
// INSTR_LO | waiting for the low byte; a write is issued on the next cycle
// DONE     | load finished; CPU released
// ERROR    | count was too large for the memory; nothing was written
//
module imem_loader #(
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    // Largest instruction count that still fits in the memory. One extra bit
    // keeps the compare against a 16-bit count unsigned and overflow-free.
    localparam logic [16:0] MAX_INSTR = 17'(MEM_SIZE / 4);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LEN_HI   = 3'd1,
        S_LEN_LO   = 3'd2,
        S_INSTR_HI = 3'd3,
        S_INSTR_LO = 3'd4,
        S_DONE     = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] count;
    logic [15:0] index;
    logic [7:0]  instr_hi;

    logic        accept;
    logic [15:0] len_full;
    logic [15:0] index_next;
    logic        len_zero;
    logic        len_too_big;

    // in_ready is a registered copy of "state is one of the four byte-taking
    // states", so the handshake never depends on in_valid.
    assign accept      = in_valid && in_ready;
    assign len_full    = {len_hi, in_data};
    assign index_next  = index + 16'd1;
    assign len_zero    = (len_full == 16'd0);
    assign len_too_big = ({1'b0, len_full} > MAX_INSTR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            len_hi   <= 8'd0;
            count    <= 16'd0;
            index    <= 16'd0;
            instr_hi <= 8'd0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            wr_en <= 1'b0;

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_LEN_HI;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end

                S_LEN_HI: begin
                    if (accept) begin
                        len_hi <= in_data;
                        state  <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (accept) begin
                        count <= len_full;
                        index <= 16'd0;
                        if (len_zero) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (len_too_big) begin
                            state    <= S_ERROR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= S_INSTR_HI;
                        end
                    end
                end

                S_INSTR_HI: begin
                    if (accept) begin
                        instr_hi <= in_data;
                        state    <= S_INSTR_LO;
                    end
                end

                S_INSTR_LO: begin
                    if (accept) begin
                        // Write goes out the cycle after the low-byte accept;
                        // for the last word that is also the first DONE cycle.
                        wr_en   <= 1'b1;
                        wr_addr <= ADDR_W'({index, 2'b00});
                        wr_data <= DATA_W'({instr_hi, in_data});
                        index   <= index_next;
                        if (index_next == count) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_INSTR_HI;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    imem_loader dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        e_ready;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_data;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    // Every write seen on the memory port, sampled mid-cycle.
    logic [15:0] got_addr[$];
    logic [15:0] got_data[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one clock; return just after the edge (outputs stable).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic s, input logic v, input logic [7:0] d,
                       input logic er, input logic ew, input logic [15:0] ea,
                       input logic [15:0] ed, input logic eb, input logic edn,
                       input logic ee);
        vec_t t;
        t.rst_n = r;  t.start = s;  t.valid = v;  t.data = d;
        t.e_ready = er; t.e_wr = ew; t.e_addr = ea; t.e_data = ed;
        t.e_busy = eb; t.e_done = edn; t.e_err = ee;
        vecs.push_back(t);
    endtask

    task automatic do_start();
        start = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("start_busy",  32'(busy), 1);
        chk("start_ready", 32'(in_ready), 1);
        chk("start_done",  32'(done), 0);
        chk("start_error", 32'(error), 0);
        chk("start_hold",  32'(cpu_hold), 1);
    endtask

    // Present one byte after `gap` idle cycles; checks stall behaviour and the
    // one-cycle write latency after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit exp_wr,
                             input logic [15:0] exp_addr, input logic [15:0] exp_data);
        int n;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            tick();
            chk("stall_wr", 32'(wr_en), 0);
            chk("stall_ready", 32'(in_ready), 1);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_ready required=ready");
        end
        tick();
        in_valid = 1'b0;
        chk("wr_latency", 32'(wr_en), 32'(exp_wr));
        if (exp_wr) begin
            chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
            chk("wr_data", 32'(wr_data), 32'(exp_data));
        end
    endtask

    function automatic byte_q_t build(input int n);
        byte_q_t q;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        if (n >= 1 && n <= 256)
            for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    // Reference: count N from the first two bytes; N==0 finishes with no
    // writes, N>256 is rejected, otherwise word k goes to address 4k.
    task automatic run_load(input byte_q_t bytes, input int gap_lo, input int gap_hi);
        int          n, nsend, k;
        bit          err, ok, is_lo;
        logic [15:0] ea[$];
        logic [15:0] ed[$];
        n   = {bytes[0], bytes[1]};
        err = (n > 256);
        ok  = (n != 0) && !err;
        if (ok)
            for (int i = 0; i < n; i++) begin
                ea.push_back(16'(i * 4));
                ed.push_back({bytes[2 + 2 * i], bytes[3 + 2 * i]});
            end
        nsend = ok ? 2 + 2 * n : 2;
        got_addr.delete();
        got_data.delete();
        do_start();
        for (int i = 0; i < nsend; i++) begin
            is_lo = ok && (i >= 3) && (((i - 3) % 2) == 0);
            k = (i >= 3) ? (i - 3) / 2 : 0;
            send_byte(bytes[i], $urandom_range(gap_lo, gap_hi), is_lo, 16'(k * 4),
                      (i >= 3) ? {bytes[i - 1], bytes[i]} : 16'h0);
        end
        chk("end_done",  32'(done), 32'(!err));
        chk("end_error", 32'(error), 32'(err));
        chk("end_busy",  32'(busy), 0);
        chk("end_hold",  32'(cpu_hold), 32'(err));
        chk("end_ready", 32'(in_ready), 0);
        tick();
        chk("post_wr", 32'(wr_en), 0);
        chk("write_count", 32'(got_addr.size()), 32'(ea.size()));
        if (got_addr.size() == ea.size())
            for (int i = 0; i < ea.size(); i++) begin
                chk($sformatf("w%0d_addr", i), 32'(got_addr[i]), 32'(ea[i]));
                chk($sformatf("w%0d_data", i), 32'(got_data[i]), 32'(ed[i]));
            end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        byte_q_t q;
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // rst st vl data  rdy wr addr     data     bsy dn er
        add(0, 0, 0, 8'h00, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 1, 0, 8'h00, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(1, 0, 1, 8'h00, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(1, 0, 1, 8'h03, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(1, 0, 1, 8'h12, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(1, 0, 1, 8'h34, 1, 1, 16'h0000, 16'h1234, 1, 0, 0);
        add(1, 0, 1, 8'hAB, 1, 0, 16'h0000, 16'h1234, 1, 0, 0);
        add(1, 0, 1, 8'hCD, 1, 1, 16'h0004, 16'hABCD, 1, 0, 0);
        add(1, 0, 1, 8'h0F, 1, 0, 16'h0004, 16'hABCD, 1, 0, 0);
        add(1, 0, 1, 8'hF0, 0, 1, 16'h0008, 16'h0FF0, 0, 1, 0);
        add(1, 0, 1, 8'h55, 0, 0, 16'h0008, 16'h0FF0, 0, 1, 0);
        add(1, 1, 0, 8'h00, 1, 0, 16'h0008, 16'h0FF0, 1, 0, 0);
        add(1, 0, 1, 8'h00, 1, 0, 16'h0008, 16'h0FF0, 1, 0, 0);
        add(1, 0, 1, 8'h00, 0, 0, 16'h0008, 16'h0FF0, 0, 1, 0);
        add(1, 1, 0, 8'h00, 1, 0, 16'h0008, 16'h0FF0, 1, 0, 0);
        add(1, 0, 1, 8'h01, 1, 0, 16'h0008, 16'h0FF0, 1, 0, 0);
        add(1, 0, 1, 8'h01, 0, 0, 16'h0008, 16'h0FF0, 0, 0, 1);
        add(1, 0, 1, 8'h22, 0, 0, 16'h0008, 16'h0FF0, 0, 0, 1);
        add(1, 1, 0, 8'h00, 1, 0, 16'h0008, 16'h0FF0, 1, 0, 0);
        add(1, 0, 1, 8'h00, 1, 0, 16'h0008, 16'h0FF0, 1, 0, 0);
        add(1, 0, 1, 8'h01, 1, 0, 16'h0008, 16'h0FF0, 1, 0, 0);
        add(1, 0, 1, 8'hBE, 1, 0, 16'h0008, 16'h0FF0, 1, 0, 0);
        add(1, 0, 1, 8'hEF, 0, 1, 16'h0000, 16'hBEEF, 0, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 1, 1, 8'h07, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(1, 0, 1, 8'h00, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(1, 0, 1, 8'h00, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset_n  = vecs[i].rst_n;
            start    = vecs[i].start;
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            tick();
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_wr", i),    32'(wr_en),    32'(vecs[i].e_wr));
            chk($sformatf("v%0d_addr", i),  32'(wr_addr),  32'(vecs[i].e_addr));
            chk($sformatf("v%0d_data", i),  32'(wr_data),  32'(vecs[i].e_data));
            chk($sformatf("v%0d_busy", i),  32'(busy),     32'(vecs[i].e_busy));
            chk($sformatf("v%0d_done", i),  32'(done),     32'(vecs[i].e_done));
            chk($sformatf("v%0d_err", i),   32'(error),    32'(vecs[i].e_err));
            chk($sformatf("v%0d_hold", i),  32'(cpu_hold), 32'(!vecs[i].e_done));
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Three idle cycles before every byte.
        q = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
        run_load(q, 3, 3);

        // Largest load that fits: last word lands at 0x3FC.
        run_load(build(256), 0, 0);

        // Reset after the second write of a four-word load.
        got_addr.delete();
        got_data.delete();
        do_start();
        send_byte(8'h00, 0, 0, 16'h0, 16'h0);
        send_byte(8'h04, 0, 0, 16'h0, 16'h0);
        send_byte(8'hA1, 0, 0, 16'h0, 16'h0);
        send_byte(8'hA2, 0, 1, 16'h0000, 16'hA1A2);
        send_byte(8'hB1, 0, 0, 16'h0, 16'h0);
        send_byte(8'hB2, 0, 1, 16'h0004, 16'hB1B2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_wr",    32'(wr_en), 0);
        chk("rst_addr",  32'(wr_addr), 0);
        chk("rst_data",  32'(wr_data), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_hold",  32'(cpu_hold), 1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'hC0 + i);
            tick();
            chk("rst_ignore_ready", 32'(in_ready), 0);
            chk("rst_ignore_wr", 32'(wr_en), 0);
        end
        in_valid = 1'b0;
        tick();
        chk("rst_write_count", 32'(got_addr.size()), 2);

        // start pulsed mid-load is ignored.
        got_addr.delete();
        got_data.delete();
        do_start();
        send_byte(8'h00, 0, 0, 16'h0, 16'h0);
        send_byte(8'h03, 0, 0, 16'h0, 16'h0);
        send_byte(8'h11, 0, 0, 16'h0, 16'h0);
        send_byte(8'h11, 0, 1, 16'h0000, 16'h1111);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midstart_busy",  32'(busy), 1);
        chk("midstart_ready", 32'(in_ready), 1);
        send_byte(8'h22, 0, 0, 16'h0, 16'h0);
        send_byte(8'h22, 0, 1, 16'h0004, 16'h2222);
        send_byte(8'h33, 0, 0, 16'h0, 16'h0);
        send_byte(8'h33, 0, 1, 16'h0008, 16'h3333);
        chk("midstart_done", 32'(done), 1);
        tick();
        chk("midstart_count", 32'(got_addr.size()), 3);

        // Randomised loads, including empty and oversized counts.
        for (int t = 0; t < 10; t++) begin
            int r, n;
            r = $urandom_range(0, 9);
            if (r == 0)      n = 0;
            else if (r == 1) n = (t % 2 == 0) ? 257 + $urandom_range(0, 2000) : 65535;
            else             n = $urandom_range(1, 12);
            run_load(build(n), 0, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
